// File: rtl/noc_ring_node.sv
// noc_ring_node: ring stop with inj/ring input FIFOs, RR arbitration to ej/ring_out, drops dest >= NUM_NODES.
// Latency: 2 cycles from input acceptance to registered output valid; sustains 1 flit/cycle per output.
// Backpressure: input ready = FIFO not full (no pop bypass); output regs hold until ready. NOC_STATS_EN adds counters.

module noc_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

module noc_ring_node #(
  parameter int NODE_ID    = 9,
  parameter int NUM_NODES  = 32,
  parameter int FLIT_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [FLIT_W-1:0] inj_data,
  input  logic              inj_valid,
  output logic              inj_ready,
  output logic [FLIT_W-1:0] ej_data,
  output logic              ej_valid,
  input  logic              ej_ready,
  input  logic [FLIT_W-1:0] ring_in_data,
  input  logic              ring_in_valid,
  output logic              ring_in_ready,
  output logic [FLIT_W-1:0] ring_out_data,
  output logic              ring_out_valid,
  input  logic              ring_out_ready,
  output logic              drop_pulse
`ifdef NOC_STATS_EN
  ,
  output logic [15:0]       stat_fwd_cnt,
  output logic [15:0]       stat_ej_cnt,
  output logic [15:0]       stat_drop_cnt
`endif
);
  localparam logic [5:0] NODE_ID_L   = 6'(NODE_ID);
  localparam logic [6:0] NUM_NODES_L = 7'(NUM_NODES);

  logic [FLIT_W-1:0] inj_head, ring_head;
  logic inj_full, inj_empty, ring_full, ring_empty;
  logic inj_push, ring_push, inj_pop, ring_pop;
  logic [5:0] inj_dest, ring_dest;
  logic inj_ej, inj_fwd, inj_drop, ring_ej, ring_fwd, ring_drop;
  logic ej_free, fwd_free;
  logic gnt_inj_ej, gnt_ring_ej, gnt_inj_fwd, gnt_ring_fwd;
  logic ej_rr_ring, fwd_rr_ring;

  assign inj_ready     = !inj_full && !ARESET;
  assign ring_in_ready = !ring_full && !ARESET;
  assign inj_push      = inj_valid && inj_ready;
  assign ring_push     = ring_in_valid && ring_in_ready;

  noc_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_inj_fifo (
    .clk(ACLK), .rst(ARESET), .push(inj_push), .push_dat(inj_data),
    .pop(inj_pop), .head_dat(inj_head), .full(inj_full), .empty(inj_empty)
  );

  noc_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_ring_fifo (
    .clk(ACLK), .rst(ARESET), .push(ring_push), .push_dat(ring_in_data),
    .pop(ring_pop), .head_dat(ring_head), .full(ring_full), .empty(ring_empty)
  );

  // Destination is always the top 6 bits regardless of FLIT_W.
  assign inj_dest  = inj_head[FLIT_W-1 -: 6];
  assign ring_dest = ring_head[FLIT_W-1 -: 6];

  assign inj_drop  = !inj_empty && ({1'b0, inj_dest} >= NUM_NODES_L);
  assign inj_ej    = !inj_empty && !inj_drop && (inj_dest == NODE_ID_L);
  assign inj_fwd   = !inj_empty && !inj_drop && !inj_ej;
  assign ring_drop = !ring_empty && ({1'b0, ring_dest} >= NUM_NODES_L);
  assign ring_ej   = !ring_empty && !ring_drop && (ring_dest == NODE_ID_L);
  assign ring_fwd  = !ring_empty && !ring_drop && !ring_ej;

  assign ej_free  = !ej_valid || ej_ready;
  assign fwd_free = !ring_out_valid || ring_out_ready;

  assign gnt_ring_ej  = ej_free && ring_ej && (!inj_ej || ej_rr_ring);
  assign gnt_inj_ej   = ej_free && inj_ej && (!ring_ej || !ej_rr_ring);
  assign gnt_ring_fwd = fwd_free && ring_fwd && (!inj_fwd || fwd_rr_ring);
  assign gnt_inj_fwd  = fwd_free && inj_fwd && (!ring_fwd || !fwd_rr_ring);

  // Each head has exactly one class, so at most one pop per FIFO per cycle.
  assign inj_pop  = gnt_inj_ej || gnt_inj_fwd || inj_drop;
  assign ring_pop = gnt_ring_ej || gnt_ring_fwd || ring_drop;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ej_valid       <= 1'b0;
      ej_data        <= '0;
      ring_out_valid <= 1'b0;
      ring_out_data  <= '0;
      drop_pulse     <= 1'b0;
      ej_rr_ring     <= 1'b1;
      fwd_rr_ring    <= 1'b1;
    end else begin
      drop_pulse <= inj_drop || ring_drop;

      if (gnt_ring_ej || gnt_inj_ej) begin
        ej_valid <= 1'b1;
        ej_data  <= gnt_ring_ej ? ring_head : inj_head;
      end else if (ej_ready) begin
        ej_valid <= 1'b0;
      end

      if (gnt_ring_fwd || gnt_inj_fwd) begin
        ring_out_valid <= 1'b1;
        ring_out_data  <= gnt_ring_fwd ? ring_head : inj_head;
      end else if (ring_out_ready) begin
        ring_out_valid <= 1'b0;
      end

      // Priority only rotates after a contested grant.
      if (ej_free && ring_ej && inj_ej)    ej_rr_ring  <= !ej_rr_ring;
      if (fwd_free && ring_fwd && inj_fwd) fwd_rr_ring <= !fwd_rr_ring;
    end
  end

`ifdef NOC_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stat_fwd_cnt  <= '0;
      stat_ej_cnt   <= '0;
      stat_drop_cnt <= '0;
    end else begin
      stat_fwd_cnt  <= sat_add(stat_fwd_cnt, {1'b0, ring_out_valid && ring_out_ready});
      stat_ej_cnt   <= sat_add(stat_ej_cnt, {1'b0, ej_valid && ej_ready});
      stat_drop_cnt <= sat_add(stat_drop_cnt, {1'b0, inj_drop} + {1'b0, ring_drop});
    end
  end
`endif
endmodule

// File: tb/tb_noc_ring_node.sv
// Directed bench for noc_ring_node: reset, forward, eject/loopback, arbitration, backpressure, drop, mid-run reset.
module tb_noc_ring_node;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] inj_data, ej_data, ring_in_data, ring_out_data;
  logic        inj_valid, inj_ready, ej_valid, ej_ready;
  logic        ring_in_valid, ring_in_ready, ring_out_valid, ring_out_ready;
  logic        drop_pulse;
`ifdef NOC_STATS_EN
  logic [15:0] stat_fwd_cnt, stat_ej_cnt, stat_drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  noc_ring_node #(.NODE_ID(9), .NUM_NODES(32), .FLIT_W(16), .FIFO_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .ej_data(ej_data), .ej_valid(ej_valid), .ej_ready(ej_ready),
    .ring_in_data(ring_in_data), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
    .ring_out_data(ring_out_data), .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
    .drop_pulse(drop_pulse)
`ifdef NOC_STATS_EN
    ,
    .stat_fwd_cnt(stat_fwd_cnt), .stat_ej_cnt(stat_ej_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  logic [15:0] got [$];
  int n_out;
  logic hs;

  initial begin
    ARESET = 1'b1; inj_valid = 0; inj_data = 0; ring_in_valid = 0; ring_in_data = 0;
    ej_ready = 1; ring_out_ready = 1;
    tick();
    chk("rst_inj_ready", {15'b0, inj_ready}, 16'h0);
    chk("rst_ring_in_ready", {15'b0, ring_in_ready}, 16'h0);
    tick();
    ARESET = 1'b0;
    #1;
    chk("rst_ring_out_valid", {15'b0, ring_out_valid}, 16'h0);
    chk("rst_ej_valid", {15'b0, ej_valid}, 16'h0);
    chk("rst_ring_out_data", ring_out_data, 16'h0);
    chk("rst_drop_pulse", {15'b0, drop_pulse}, 16'h0);
    chk("post_rst_inj_ready", {15'b0, inj_ready}, 16'h1);

    // Forward: dest 10
    inj_data = 16'h2923; inj_valid = 1;
    tick();                        // E0: accepted
    inj_valid = 0;
    chk("fwd_valid_e0", {15'b0, ring_out_valid}, 16'h0);
    tick();                        // E1: registered
    chk("fwd_valid_e1", {15'b0, ring_out_valid}, 16'h1);
    chk("fwd_data", ring_out_data, 16'h2923);
    chk("fwd_no_ej", {15'b0, ej_valid}, 16'h0);
    tick();
    chk("fwd_valid_gone", {15'b0, ring_out_valid}, 16'h0);

    // Eject from ring, then loopback from injection
    ring_in_data = 16'h2523; ring_in_valid = 1;
    tick();
    ring_in_valid = 0;
    tick();
    chk("ej_valid", {15'b0, ej_valid}, 16'h1);
    chk("ej_data", ej_data, 16'h2523);
    chk("ej_no_fwd", {15'b0, ring_out_valid}, 16'h0);
    tick();
    inj_data = 16'h2401; inj_valid = 1;
    tick();
    inj_valid = 0;
    tick();
    chk("loop_ej_valid", {15'b0, ej_valid}, 16'h1);
    chk("loop_ej_data", ej_data, 16'h2401);
    tick();
    chk("loop_ej_gone", {15'b0, ej_valid}, 16'h0);

    // Arbitration: both streaming to ring_out, ring first then alternate
    inj_data = 16'h2923; inj_valid = 1;
    ring_in_data = 16'h2C01; ring_in_valid = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("arb_valid_%0d", k), {15'b0, ring_out_valid}, 16'h1);
      chk($sformatf("arb_data_%0d", k), ring_out_data, (k % 2 == 0) ? 16'h2C01 : 16'h2923);
    end
    inj_valid = 0; ring_in_valid = 0;
    repeat (14) tick();
    chk("arb_drained", {15'b0, ring_out_valid}, 16'h0);

    // Backpressure: 5 accepted, 6th stalls
    ring_out_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      inj_data = 16'h2900 + 16'(k); inj_valid = 1;
      #1;
      chk($sformatf("bp_ready_%0d", k), {15'b0, inj_ready}, (k <= 5) ? 16'h1 : 16'h0);
      if (k <= 5) tick();
    end
    tick();
    chk("bp_still_stalled", {15'b0, inj_ready}, 16'h0);
    ring_out_ready = 1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (ring_out_valid) got.push_back(ring_out_data);
      hs = inj_valid && inj_ready;
      tick();
      if (hs) inj_valid = 0;
    end
    chk("bp_count", 16'(got.size()), 16'd6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      chk($sformatf("bp_order_%0d", k), got[k], 16'h2901 + 16'(k));

    // Invalid destination (dest 36)
    inj_data = 16'h9000; inj_valid = 1;
    tick();
    inj_valid = 0;
    chk("drop_e0", {15'b0, drop_pulse}, 16'h0);
    tick();
    chk("drop_pulse", {15'b0, drop_pulse}, 16'h1);
    chk("drop_no_fwd", {15'b0, ring_out_valid}, 16'h0);
    chk("drop_no_ej", {15'b0, ej_valid}, 16'h0);
`ifdef NOC_STATS_EN
    chk("stat_drop_1", stat_drop_cnt, 16'd1);
`endif
    tick();
    chk("drop_pulse_end", {15'b0, drop_pulse}, 16'h0);

    // Two drops in the same cycle: one pulse
    inj_data = 16'h9000; inj_valid = 1;
    ring_in_data = 16'hFC00; ring_in_valid = 1;
    tick();
    inj_valid = 0; ring_in_valid = 0;
    tick();
    chk("drop2_pulse", {15'b0, drop_pulse}, 16'h1);
    tick();
    chk("drop2_pulse_end", {15'b0, drop_pulse}, 16'h0);
`ifdef NOC_STATS_EN
    chk("stat_drop_3", stat_drop_cnt, 16'd3);
`endif

    // Reset mid-operation: 1 in output reg, 3 buffered
    ring_out_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      inj_data = 16'h2A00 + 16'(k); inj_valid = 1;
      tick();
    end
    inj_valid = 0;
    tick();
    chk("mid_valid_before", {15'b0, ring_out_valid}, 16'h1);
    ARESET = 1; inj_data = 16'h2A05; inj_valid = 1;
    tick();
    ARESET = 0; inj_valid = 0;
    #1;
    chk("mid_ring_out_valid", {15'b0, ring_out_valid}, 16'h0);
    chk("mid_ej_valid", {15'b0, ej_valid}, 16'h0);
    chk("mid_inj_ready", {15'b0, inj_ready}, 16'h1);
    chk("mid_ring_out_data", ring_out_data, 16'h0);
    ring_out_ready = 1;
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ring_out_valid) n_out++;
    end
    chk("mid_no_leftover", 16'(n_out), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
